// File: rtl/i2c_mem_controller.sv
// I2C master for the pointer-style memory protocol: START, dev+W, mem addr, then N write bytes, or repeated START, dev+R and N read bytes, then STOP.
// Latency: 4*QTR clk per bit slot; START/RSTART/STOP take 4 quarters each; done pulses 1 clk after STOP ends.
// Backpressure: a new start is accepted only when busy=0; write bytes are pulled one per wr_req; no SCL stretching.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   start/rw/dev_addr/mem_addr/len   command, latched when start is accepted
//   wr_data/wr_req    write byte pull (wr_data captured in the wr_req cycle)
//   rd_data/rd_valid  received byte and its one-cycle strobe
//   busy/done/nack_err  transaction status
//   scl_oe/sda_oe/sda_i open-drain pad controls (1 = pull low) and SDA input
module i2c_mem_controller #(
  parameter int QTR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] len,
  input  logic [7:0] wr_data,
  output logic       wr_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QTR - 1);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] START  = 4'd1;
  localparam logic [3:0] DEV_W  = 4'd2;
  localparam logic [3:0] ACK1   = 4'd3;
  localparam logic [3:0] MADDR  = 4'd4;
  localparam logic [3:0] ACK2   = 4'd5;
  localparam logic [3:0] WDATA  = 4'd6;
  localparam logic [3:0] ACK3   = 4'd7;
  localparam logic [3:0] RSTART = 4'd8;
  localparam logic [3:0] DEV_R  = 4'd9;
  localparam logic [3:0] ACK4   = 4'd10;
  localparam logic [3:0] RDATA  = 4'd11;
  localparam logic [3:0] MACK   = 4'd12;
  localparam logic [3:0] STOP   = 4'd13;

  logic [3:0]    state;
  logic [QW-1:0] qcnt;
  logic [1:0]    ph;        // quarter within the current bit / condition
  logic [2:0]    bitcnt;    // 7..0 inside a byte
  logic [7:0]    shreg;     // transmit MSB-first / receive shift register
  logic [7:0]    cnt;       // data bytes still to move
  logic          rw_q;
  logic [6:0]    dev_q;
  logic [7:0]    mem_q;
  logic          ack_smp;   // last SDA sample, consumed at the end of ACK slots

  logic       tick, smp, bit_end;
  logic       scl_low, sda_low;
  logic [3:0] byte_next;

  assign busy    = (state != IDLE);
  assign tick    = busy && (qcnt == QMAX);
  assign smp     = tick && (ph == 2'd2);
  assign bit_end = tick && (ph == 2'd3);
  // First clk of each write byte: the new byte is loaded into shreg on this edge.
  assign wr_req  = (state == WDATA) && (bitcnt == 3'd7) && (ph == 2'd0) && (qcnt == '0);

  // Bus waveform decode; registered below so pad drivers never see decode glitches.
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state)
      START:  begin scl_low = ph[1];                         sda_low = (ph != 2'd0); end
      RSTART: begin scl_low = (ph == 2'd0) || (ph == 2'd3);  sda_low = ph[1];        end
      STOP:   begin scl_low = (ph == 2'd0);                  sda_low = !ph[1];       end
      DEV_W, MADDR, WDATA, DEV_R: begin
        scl_low = !ph[1];
        sda_low = !shreg[7];
      end
      ACK1, ACK2, ACK3, ACK4, RDATA: scl_low = !ph[1];
      MACK: begin
        scl_low = !ph[1];
        sda_low = (cnt != 8'd0);   // ACK while bytes remain, NACK the last one
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_next = STOP;
    case (state)
      DEV_W:   byte_next = ACK1;
      MADDR:   byte_next = ACK2;
      WDATA:   byte_next = ACK3;
      DEV_R:   byte_next = ACK4;
      RDATA:   byte_next = MACK;
      default: byte_next = STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      qcnt     <= '0;
      ph       <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      cnt      <= '0;
      rw_q     <= 1'b0;
      dev_q    <= '0;
      mem_q    <= '0;
      ack_smp  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      nack_err <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      scl_oe   <= scl_low;
      sda_oe   <= sda_low;
      if (state == IDLE) begin
        qcnt   <= '0;
        ph     <= '0;
        bitcnt <= '0;
        if (start) begin
          state    <= START;
          rw_q     <= rw;
          dev_q    <= dev_addr;
          mem_q    <= mem_addr;
          cnt      <= len;
          bitcnt   <= 3'd7;
          nack_err <= 1'b0;
        end
      end else begin
        qcnt <= tick ? '0 : qcnt + 1'b1;
        if (tick) ph <= ph + 2'd1;
        if (wr_req) shreg <= wr_data;
        if (smp) begin
          ack_smp <= sda_i;
          if (state == RDATA) begin
            shreg <= {shreg[6:0], sda_i};
            if (bitcnt == 3'd0) begin
              rd_data  <= {shreg[6:0], sda_i};
              rd_valid <= 1'b1;
              cnt      <= cnt - 8'd1;
            end
          end
        end
        if (bit_end) begin
          bitcnt <= 3'd7;
          case (state)
            START: begin
              state <= DEV_W;
              shreg <= {dev_q, 1'b0};
            end
            DEV_W, MADDR, WDATA, DEV_R, RDATA: begin
              if (state != RDATA) shreg <= {shreg[6:0], 1'b0};
              if (bitcnt != 3'd0) bitcnt <= bitcnt - 3'd1;
              else                state  <= byte_next;
            end
            ACK1: begin
              if (ack_smp) begin
                nack_err <= 1'b1;
                state    <= STOP;
              end else begin
                state <= MADDR;
                shreg <= mem_q;
              end
            end
            ACK2: begin
              if (ack_smp) begin
                nack_err <= 1'b1;
                state    <= STOP;
              end else if (cnt == 8'd0) state <= STOP;   // pointer set only
              else if (rw_q)            state <= RSTART;
              else                      state <= WDATA;
            end
            ACK3: begin
              if (ack_smp) begin
                nack_err <= 1'b1;
                state    <= STOP;
              end else begin
                cnt   <= cnt - 8'd1;
                state <= (cnt == 8'd1) ? STOP : WDATA;
              end
            end
            ACK4: begin
              if (ack_smp) begin
                nack_err <= 1'b1;
                state    <= STOP;
              end else state <= RDATA;
            end
            MACK:   state <= (cnt != 8'd0) ? RDATA : STOP;
            RSTART: begin
              state <= DEV_R;
              shreg <= {dev_q, 1'b1};
            end
            STOP: begin
              state <= IDLE;
              done  <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_controller.sv
// Bench for i2c_mem_controller: behavioural I2C subordinate decoding the pads, plus expected bus traffic built from the protocol rules.
// Latency: transactions are awaited with a cycle budget sized from the byte count.
// Backpressure: write bytes are supplied on each wr_req; subordinate ACK/NACK is scripted per transaction.
module tb_i2c_mem_controller;

  localparam int QTR = 4;
  localparam int EV_S = 256;
  localparam int EV_P = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] mem_addr = '0;
  logic [7:0] len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_req, rd_valid, busy, done, nack_err, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic       sda_i;
  logic       slave_low = 1'b0;

  assign sda_i = ~sda_oe & ~slave_low;   // wired-AND with pull-up

  always #5 clk = ~clk;

  i2c_mem_controller #(.QTR(QTR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .dev_addr(dev_addr),
    .mem_addr(mem_addr), .len(len), .wr_data(wr_data), .wr_req(wr_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .nack_err(nack_err), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  int ncmp = 0;
  int nfail = 0;

  byte unsigned wr_bytes[$];
  byte unsigned rd_bytes[$];
  int  bus_log[$];
  int  mack_log[$];
  int  rdv_log[$];
  int  wr_cnt, rd_ptr, rx_idx, nack_idx;
  bit  done_seen, done_nack, done_busy;

  // subordinate decoder state
  bit         p_scl = 1'b1, p_sda = 1'b1;
  int         bitidx = 0;
  int         mode = 0;          // 0 address, 1 receiving, 2 transmitting
  logic [7:0] cur = '0;
  logic [7:0] txb = '0;

  task automatic load_tx();
    txb = (rd_ptr < rd_bytes.size()) ? rd_bytes[rd_ptr] : 8'hFF;
    rd_ptr++;
    slave_low = ~txb[7];
  endtask

  always @(negedge clk) begin
    bit scl, sda;
    scl = ~scl_oe;
    sda = sda_i;
    if (!rst_n) begin
      slave_low = 1'b0;
      bitidx = 0;
      mode = 0;
      p_scl = 1'b1;
      p_sda = 1'b1;
    end else begin
      if (wr_req) wr_cnt++;
      else wr_data = (wr_cnt < wr_bytes.size()) ? wr_bytes[wr_cnt] : 8'h00;
      if (rd_valid) rdv_log.push_back(rd_data);
      if (done) begin
        done_seen = 1'b1;
        done_nack = nack_err;
        done_busy = busy;
      end
      if (p_scl && scl && p_sda && !sda) begin
        bus_log.push_back(EV_S);
        bitidx = 0; mode = 0; slave_low = 1'b0;
      end else if (p_scl && scl && !p_sda && sda) begin
        bus_log.push_back(EV_P);
        bitidx = 0; mode = 0; slave_low = 1'b0;
      end else if (!p_scl && scl) begin
        if (bitidx < 8) begin
          cur = {cur[6:0], sda};
          bitidx++;
          if (bitidx == 8) bus_log.push_back(cur);
        end else if (bitidx == 8) begin
          bitidx = 9;
          if (mode == 2) mack_log.push_back(sda);
        end
      end else if (p_scl && !scl) begin
        if (bitidx == 8) begin
          if (mode == 2) slave_low = 1'b0;
          else begin
            slave_low = (rx_idx != nack_idx);
            rx_idx++;
          end
        end else if (bitidx == 9) begin
          bitidx = 0;
          if (mode == 0) begin
            mode = cur[0] ? 2 : 1;
            slave_low = 1'b0;
            if (mode == 2) load_tx();
          end else if (mode == 2) begin
            if (mack_log.size() > 0 && mack_log[$] == 0) load_tx();
            else slave_low = 1'b0;
          end else slave_low = 1'b0;
        end else if (mode == 2 && bitidx >= 1 && bitidx <= 7) begin
          slave_low = ~txb[7 - bitidx];
        end
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic prep(input int t_len, input int t_nack);
    @(posedge clk); #1;
    wr_bytes.delete(); rd_bytes.delete();
    bus_log.delete(); mack_log.delete(); rdv_log.delete();
    for (int i = 0; i < t_len; i++) begin
      wr_bytes.push_back(8'($urandom));
      rd_bytes.push_back(8'($urandom));
    end
    wr_cnt = 0; rd_ptr = 0; rx_idx = 0; nack_idx = t_nack;
    done_seen = 1'b0; done_nack = 1'b0; done_busy = 1'b1;
  endtask

  task automatic issue(input bit t_rw, input logic [6:0] t_dev, input logic [7:0] t_mem, input int t_len);
    @(negedge clk);
    rw = t_rw; dev_addr = t_dev; mem_addr = t_mem; len = 8'(t_len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rw = 1'($urandom); dev_addr = 7'($urandom); mem_addr = 8'($urandom); len = 8'($urandom);
  endtask

  // Issue a command, wait for done and compare everything against the protocol rules.
  task automatic go(input bit t_rw, input logic [6:0] t_dev, input logic [7:0] t_mem,
                    input int t_len, input int t_nack, input bit poke);
    int exp_log[$];
    int exp_mack[$];
    int exp_wr, exp_rd, nd, cyc, budget, n;
    bit exp_nack;
    exp_wr = 0; exp_rd = 0; exp_nack = 1'b0;
    issue(t_rw, t_dev, t_mem, t_len);
    if (poke) begin
      repeat (50) @(negedge clk);
      rw = ~t_rw; dev_addr = ~t_dev; len = 8'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    budget = (t_len + 6) * 36 * QTR + 200;
    cyc = 0;
    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);

    exp_log.push_back(EV_S);
    exp_log.push_back({t_dev, 1'b0});
    if (t_nack == 0) exp_nack = 1'b1;
    else begin
      exp_log.push_back(t_mem);
      if (t_nack == 1) exp_nack = 1'b1;
      else if (!t_rw) begin
        nd = t_len;
        if (t_nack >= 2 && t_nack - 2 < t_len) begin
          nd = t_nack - 1;
          exp_nack = 1'b1;
        end
        for (int i = 0; i < nd; i++) exp_log.push_back(wr_bytes[i]);
        exp_wr = nd;
      end else if (t_len > 0) begin
        exp_log.push_back(EV_S);
        exp_log.push_back({t_dev, 1'b1});
        for (int i = 0; i < t_len; i++) begin
          exp_log.push_back(rd_bytes[i]);
          exp_mack.push_back((i == t_len - 1) ? 1 : 0);
        end
        exp_rd = t_len;
      end
    end
    exp_log.push_back(EV_P);

    chk("done_seen", done_seen, 1);
    chk("nack_err", done_nack, exp_nack);
    chk("busy_at_done", done_busy, 0);
    chk("wr_req_count", wr_cnt, exp_wr);
    chk("rd_valid_count", rdv_log.size(), exp_rd);
    n = (rdv_log.size() < exp_rd) ? rdv_log.size() : exp_rd;
    for (int i = 0; i < n; i++) chk($sformatf("rd_data[%0d]", i), rdv_log[i], rd_bytes[i]);
    chk("bus_event_count", bus_log.size(), exp_log.size());
    n = (bus_log.size() < exp_log.size()) ? bus_log.size() : exp_log.size();
    for (int i = 0; i < n; i++) chk($sformatf("bus[%0d]", i), bus_log[i], exp_log[i]);
    chk("mack_count", mack_log.size(), exp_mack.size());
    n = (mack_log.size() < exp_mack.size()) ? mack_log.size() : exp_mack.size();
    for (int i = 0; i < n; i++) chk($sformatf("mack[%0d]", i), mack_log[i], exp_mack[i]);
  endtask

  initial begin
    int cyc, t_len, t_nack, r;
    bit t_rw;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {scl_oe, sda_oe, busy, done, wr_req, rd_valid, nack_err, rd_data}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outputs", {scl_oe, sda_oe, busy, done, wr_req, rd_valid, nack_err}, 0);

    // directed write 0x50 @0x10: A5, 3C
    prep(2, -1);
    wr_bytes[0] = 8'hA5;
    wr_bytes[1] = 8'h3C;
    go(1'b0, 7'h50, 8'h10, 2, -1, 1'b0);

    // directed read 0x50 @0x20: 11, 22, 33
    prep(3, -1);
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33;
    go(1'b1, 7'h50, 8'h20, 3, -1, 1'b0);

    // device address NACK
    prep(2, 0);
    go(1'b0, 7'h51, 8'h10, 2, 0, 1'b0);

    // data NACK on 2nd of 4 write bytes (byte index 3 counting dev and mem)
    prep(4, 3);
    go(1'b0, 7'h50, 8'h44, 4, 3, 1'b0);

    // pointer-set only
    prep(0, -1);
    go(1'b0, 7'h50, 8'h5A, 0, -1, 1'b0);
    prep(0, -1);
    go(1'b1, 7'h50, 8'hC3, 0, -1, 1'b0);

    // reset during RDATA bit 4
    prep(3, -1);
    issue(1'b1, 7'h50, 8'h20, 3);
    cyc = 0;
    while (!(mode == 2 && bitidx == 4) && cyc < 4000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("reached_rdata_bit4", (mode == 2 && bitidx == 4) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {scl_oe, sda_oe, busy, done, wr_req, rd_valid, nack_err, rd_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // write after the abort, with a start pulse while busy that must be ignored
    prep(3, -1);
    go(1'b0, 7'h50, 8'h77, 3, -1, 1'b1);

    // randomized transactions
    for (int k = 0; k < 6; k++) begin
      t_rw = 1'($urandom_range(0, 1));
      t_len = $urandom_range(0, 4);
      r = $urandom_range(0, 5);
      if (r == 0) t_nack = 0;
      else if (r == 1) t_nack = t_rw ? 1 : $urandom_range(1, t_len + 1);
      else t_nack = -1;
      prep(t_len, t_nack);
      go(t_rw, 7'($urandom), 8'($urandom), t_len, t_nack, 1'b0);
    end

    // maximum length: 255 bytes, no counter wrap
    prep(255, -1);
    go(1'b0, 7'h2B, 8'h00, 255, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
